// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter states.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_INIT  = WNT;
  localparam ctr_t CTR_ALLOC = WT;

endpackage

// File: rtl/bp_sat_counter.sv
// Next state of a 2-bit saturating direction counter given the resolved outcome.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t next_ctr
);

  always_comb begin
    // NOTE: default assigned first so every path drives next_ctr and no latch is inferred.
    next_ctr = cur;
    case (cur)
      SNT: next_ctr = taken ? WNT : SNT;
      WNT: next_ctr = taken ? WT  : SNT;
      WT:  next_ctr = taken ? ST  : WNT;
      ST:  next_ctr = taken ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Branch predictor + BTB: tagged targets with 2-bit counters, looked up in IF, trained from MEM.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into the lookup index.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_hit,
  output logic             lk_taken,
  output logic [XLEN-1:0]  lk_next_pc,
  output logic [IDX_W-1:0] lk_idx,
  input  logic             up_valid,
  input  logic [XLEN-1:0]  up_pc,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  input  logic [XLEN-1:0]  up_target,
  input  logic             up_mispred,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
);

  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic [ENTRIES-1:0] valid;
  ctr_t               ctr_mem    [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];

  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  ctr_t             up_ctr_next;

  // PC bits outside the index and tag fields do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], lk_pc[XLEN-1:TAG_HI+1],
                            up_pc[TAG_LO-1:0], up_pc[XLEN-1:TAG_HI+1]};

  assign base_idx = lk_pc[IDX_W+1:2];
  assign lk_tag   = lk_pc[TAG_HI:TAG_LO];
  assign up_tag   = up_pc[TAG_HI:TAG_LO];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ghr <= '0;
    else if (clear)    ghr <= '0;
    else if (up_valid) ghr <= GHR_W'({ghr, up_taken});
  end

  assign lk_idx = base_idx ^ IDX_W'(ghr);
`else
  localparam int unused_ghr_w = GHR_W;

  assign lk_idx = base_idx;
`endif

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_hit     = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_taken   = lk_hit && ctr_mem[lk_idx][1];
  assign lk_next_pc = lk_taken ? target_mem[lk_idx] : lk_pc + XLEN'(4);

  // Training always uses the index carried from lookup, never one recomputed from up_pc.
  assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

  bp_sat_counter u_sat_counter (
    .cur      (ctr_mem[up_idx]),
    .taken    (up_taken),
    .next_ctr (up_ctr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= CTR_INIT;
    end else if (up_valid) begin
      if (up_hit) begin
        ctr_mem[up_idx] <= up_ctr_next;
      end else if (up_taken) begin
        valid[up_idx]   <= 1'b1;
        ctr_mem[up_idx] <= CTR_ALLOC;
      end
    end
  end

  // NOTE: tag/target arrays have no reset; they are only ever read behind a valid bit.
  always_ff @(posedge clk) begin
    if (up_valid && up_taken && !clear) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= up_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (up_valid) begin
      if (stat_branches != '1)              stat_branches <= stat_branches + 32'd1;
      if (up_mispred && stat_mispred != '1) stat_mispred  <= stat_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: a table model predicts each cycle's lookup and stats.
module tb_branch_predictor_btb;

  localparam int XLEN    = 64;
  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int GHR_W   = 6;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [XLEN-1:0]  lk_pc;
  logic             lk_hit;
  logic             lk_taken;
  logic [XLEN-1:0]  lk_next_pc;
  logic [IDX_W-1:0] lk_idx;
  logic             up_valid;
  logic [XLEN-1:0]  up_pc;
  logic [IDX_W-1:0] up_idx;
  logic             up_taken;
  logic [XLEN-1:0]  up_target;
  logic             up_mispred;
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispred;

  branch_predictor_btb #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .lk_next_pc(lk_next_pc), .lk_idx(lk_idx),
    .up_valid(up_valid), .up_pc(up_pc), .up_idx(up_idx), .up_taken(up_taken),
    .up_target(up_target), .up_mispred(up_mispred),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             hit;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [IDX_W-1:0] idx;
    logic [31:0]      branches;
    logic [31:0]      mispred;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: per-index entry, counter as an integer 0..3, stats as plain integers.
  bit              m_valid  [ENTRIES];
  int              m_ctr    [ENTRIES];
  longint unsigned m_tag    [ENTRIES];
  logic [XLEN-1:0] m_target [ENTRIES];
  int unsigned     m_ghr;
  longint unsigned m_br;
  longint unsigned m_mp;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int m_index(input logic [XLEN-1:0] pc);
    int b;
    b = int'((pc >> 2) % ENTRIES);
`ifdef BP_GSHARE_EN
    b = b ^ int'(m_ghr);
`endif
    return b;
  endfunction

  function automatic longint unsigned m_tagof(input logic [XLEN-1:0] pc);
    return (pc >> (2 + IDX_W)) % (64'd1 << TAG_W);
  endfunction

  function automatic logic [XLEN-1:0] pool_pc(input int k);
    return 64'h8000_0000 + 64'(k % 8) * 4 + 64'(k / 8) * 4 * ENTRIES;
  endfunction

  // Drive one cycle of stimulus, queue the expected lookup, then advance the model.
  task automatic step(input logic [XLEN-1:0] pc, input logic uv, input logic [XLEN-1:0] upc,
                      input logic tk, input logic [XLEN-1:0] tgt, input logic mp, input logic clr);
    exp_t e;
    int   li;
    int   ui;
    ui         = m_index(upc);
    lk_pc      = pc;
    up_valid   = uv;
    up_pc      = upc;
    up_idx     = IDX_W'(ui);
    up_taken   = tk;
    up_target  = tgt;
    up_mispred = mp;
    clear      = clr;

    li         = m_index(pc);
    e.hit      = m_valid[li] && (m_tag[li] == m_tagof(pc));
    e.taken    = e.hit && (m_ctr[li] >= 2);
    e.next_pc  = e.taken ? m_target[li] : pc + 64'd4;
    e.idx      = IDX_W'(li);
    e.branches = 32'(m_br);
    e.mispred  = 32'(m_mp);
    exp_q.push_back(e);

    if (uv) begin
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
    if (clr) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_ghr = 0;
    end else if (uv) begin
      if (m_valid[ui] && m_tag[ui] == m_tagof(upc)) begin
        if (tk) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
        else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        if (tk) m_target[ui] = tgt;
      end else if (tk) begin
        m_valid[ui]  = 1'b1;
        m_tag[ui]    = m_tagof(upc);
        m_target[ui] = tgt;
        m_ctr[ui]    = 2;
      end
      m_ghr = ((m_ghr << 1) | 32'(tk)) % (32'd1 << GHR_W);
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor: lookup outputs are always presented, so compare one queued entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lk_hit",        64'(lk_hit),        64'(e.hit));
        check("lk_taken",      64'(lk_taken),      64'(e.taken));
        check("lk_next_pc",    lk_next_pc,         e.next_pc);
        check("lk_idx",        64'(lk_idx),        64'(e.idx));
        check("stat_branches", 64'(stat_branches), 64'(e.branches));
        check("stat_mispred",  64'(stat_mispred),  64'(e.mispred));
      end
    end
  end

  initial begin
    localparam logic [XLEN-1:0] PC_A = 64'h1000;
    localparam logic [XLEN-1:0] PC_B = 64'h1100;
    localparam logic [XLEN-1:0] PC_C = 64'h2000;

    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_ctr[i]    = 1;
      m_tag[i]    = 0;
      m_target[i] = '0;
    end
    m_ghr = 0;
    m_br  = 0;
    m_mp  = 0;

    reset = 1'b1; clear = 1'b0; lk_pc = '0; up_valid = 1'b0; up_pc = '0; up_idx = '0;
    up_taken = 1'b0; up_target = '0; up_mispred = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, then allocate 0x1000 -> 0x0F00 (same-cycle lookup sees the old miss).
    step(PC_A, 0, '0,   0, '0,        0, 0);
    step(PC_A, 1, PC_A, 1, 64'h0F00,  1, 0);
    // Counter walks down 10 -> 01 -> 00 and holds at 00.
    step(PC_A, 1, PC_A, 0, '0,        1, 0);
    step(PC_A, 1, PC_A, 0, '0,        0, 0);
    step(PC_A, 1, PC_A, 0, '0,        0, 0);
    step(PC_A, 0, '0,   0, '0,        0, 0);
    // Counter walks up to 11, saturates, then one not-taken leaves it predicting taken.
    step(PC_A, 1, PC_A, 1, 64'h2400,  0, 0);
    step(PC_A, 1, PC_A, 1, 64'h2400,  0, 0);
    step(PC_A, 1, PC_A, 1, 64'h2800,  0, 0);
    step(PC_A, 1, PC_A, 1, 64'h2800,  0, 0);
    step(PC_A, 1, PC_A, 0, '0,        0, 0);
    step(PC_A, 0, '0,   0, '0,        0, 0);
    // Alias at +4*ENTRIES replaces the tag; the original PC then misses.
    step(PC_A, 1, PC_A + 64'(4 * ENTRIES), 1, 64'h3000, 1, 0);
    step(PC_A, 0, '0,   0, '0,        0, 0);
    step(PC_A + 64'(4 * ENTRIES), 0, '0, 0, '0, 0, 0);
    // Fall-through wraps at the top of the address space.
    step(64'hFFFF_FFFF_FFFF_FFFC, 0, '0, 0, '0, 0, 0);
    // clear together with an update: table update dropped, stats still count.
    step(PC_B, 1, PC_B, 1, 64'h4000,  0, 0);
    step(PC_B, 1, PC_C, 1, 64'h5000,  1, 1);
    step(PC_B, 0, '0,   0, '0,        0, 0);
    step(PC_C, 0, '0,   0, '0,        0, 0);
    // History pattern taken, taken, not-taken, then a lookup.
    step(PC_C, 1, PC_C, 1, 64'h6000,  0, 0);
    step(PC_C, 1, PC_C, 1, 64'h6000,  0, 0);
    step(PC_C, 1, PC_C, 0, '0,        1, 0);
    step(PC_C, 0, '0,   0, '0,        0, 0);

    // Randomized traffic over a small aliasing PC pool plus occasional wild lookups.
    for (int n = 0; n < 1500; n++) begin
      logic [XLEN-1:0] lpc;
      logic [XLEN-1:0] upc;
      logic [XLEN-1:0] tgt;
      logic            uv;
      logic            tk;
      logic            mp;
      logic            clr;
      lpc = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : pool_pc($urandom_range(0, 31));
      upc = pool_pc($urandom_range(0, 31));
      tgt = {$urandom, $urandom} & ~64'h3;
      uv  = ($urandom_range(0, 3) != 0);
      tk  = ($urandom_range(0, 99) < 65);
      mp  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 63) == 0);
      step(lpc, uv, upc, tk, tgt, mp, clr);
    end

    up_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
